instr_loader: RTL
=================

# instr_loader

Boot-time writer for the instruction memory: accepts a byte stream over a valid/ready handshake, packs bytes into 32-bit words in the same byte order the instruction memory read path uses (lowest byte address = bits 31:24), and issues word-wide write strobes starting at the reset vector region 0xBFC00000. It sits between a host/debug byte source and the write port of a writable instruction RAM, and holds the core off via `busy` until the program image is in place.

## Interface
- `BASE_ADDR`, 32'hBFC00000, byte address of the first word written
- `DEPTH_BYTES`, 4096, memory capacity in bytes (multiple of 4)
- `CNT_W`, $clog2(DEPTH_BYTES/4)+1, width of the word counter
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a new load (sampled in IDLE or DONE only)
- `byte_valid`  in  1  source has a byte on `byte_data`
- `byte_data`  in  8  stream byte
- `byte_last`  in  1  qualifies the final byte of the image (valid with `byte_valid`)
- `byte_ready`  out  1  loader accepts a byte this cycle
- `we`  out  1  one-cycle word write strobe to instruction memory
- `waddr`  out  32  word-aligned byte address (bits 1:0 always 0)
- `wdata`  out  32  packed word, first-received byte in bits 31:24
- `busy`  out  1  load in progress (LOAD or FLUSH)
- `done`  out  1  load complete, held until next `start` or `rst`
- `overflow`  out  1  sticky: bytes arrived beyond capacity and were dropped
- `words_written`  out  CNT_W  count of write strobes issued this load

## Operation
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE/DONE + `start`: clear `byte_cnt` (2 bits), shift buffer, `words_written`, `overflow`, `done`; set next write address to `BASE_ADDR`; go LOAD.
- LOAD: `byte_ready`=1. Byte accepted when `byte_valid && byte_ready`. Accepted byte shifts into buffer: buffer <= {buffer[23:0], byte_data}; `byte_cnt` increments mod 4.
- 4th byte accepted (byte_cnt==3): register word to `wdata`, current address to `waddr`, pulse `we`, address += 4, `words_written` += 1.
- Accepted byte with `byte_last`: if it completes a word, write as above and go DONE; if byte_cnt==0 after acceptance (impossible, covered) n/a; otherwise go FLUSH.
- FLUSH (one cycle): left-align partial word, pad remaining low bytes with 8'h00 (e.g. 2 bytes AA,BB -> 32'hAABB0000), write it, go DONE. `byte_ready`=0.
- Capacity: once `words_written` == DEPTH_BYTES/4, further bytes are still accepted (stream drains) but no `we` is issued, `overflow` set; `byte_last` still ends the load in DONE.
- `start` while busy: ignored. `byte_valid` in IDLE/DONE: not accepted (`byte_ready`=0).
- Address arithmetic: 32-bit, no wrap handling needed since capacity stops writes before BASE_ADDR+DEPTH_BYTES.

## Timing
- Reset values: state IDLE; `byte_ready`=0, `we`=0, `waddr`=BASE_ADDR, `wdata`=0, `busy`=0, `done`=0, `overflow`=0, `words_written`=0.
- `rst` mid-load: abort immediately, return to reset values next edge; no partial word written.
- `we` asserted the cycle after the completing byte is accepted; exactly one cycle wide; `waddr`/`wdata` valid while `we`=1.
- Full throughput: one byte per cycle sustained; a write and a new byte acceptance may occur in the same cycle.
- `byte_ready` combinational on state only (no dependence on `byte_valid`).
- `done` rises the cycle after the final `we` (or after the last accepted byte if overflowed); `busy` falls the same cycle.

## Structure
- Shared package `loader_pkg`: state enum `loader_state_t` {IDLE, LOAD, FLUSH, DONE}, `RESET_VECTOR` = 32'hBFC00000 (also used by the PC reset value).
- Single module; word packer (shift buffer + byte_cnt + pad) may be split as sub-module `byte_packer` if desired.

## Test plan
- Reset, then idle 5 cycles -> all outputs at reset values, `byte_ready`=0.
- start; bytes 13,00,00,93 (last on 4th) -> one `we` with waddr 0xBFC00000, wdata 0x13000093; `done`=1, `words_written`=1.
- start; 10 bytes 01..0A, one per cycle, last on 0A -> writes 0x01020304@BFC00000, 0x05060708@BFC00004, 0x090A0000@BFC00008 (via FLUSH); 3 words.
- Bytes with `byte_valid` toggling every other cycle -> same words/addresses as continuous stream; no accepted byte lost.
- DEPTH_BYTES=16, send 20 bytes -> 4 writes ending at 0xBFC0000C, `overflow`=1, `done`=1, `words_written`=4.
- `rst` asserted after 6 bytes of a load -> no further `we`, all outputs back to reset values next cycle; new start writes again from 0xBFC00000.

Source files
------------

// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared loader FSM encoding, reset vector, partial-word padding.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

    // Left-align the held bytes so the first-received byte lands in bits 31:24.
    function automatic logic [31:0] pad_partial(input logic [23:0] held, input logic [1:0] cnt);
        logic [31:0] word;
        case (cnt)
            2'd1:    word = {held[7:0], 24'h000000};
            2'd2:    word = {held[15:0], 16'h0000};
            2'd3:    word = {held, 8'h00};
            default: word = 32'h00000000;
        endcase
        return word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_packer
// Description : Shift buffer and byte counter that assemble big-endian words.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  data,
    output logic [1:0]  byte_cnt,
    output logic [31:0] full_word,
    output logic [31:0] pad_word
);

    logic [23:0] buf_q, buf_d;
    logic [1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q <= 24'h000000;
            cnt_q <= 2'd0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (clear) begin
            buf_d = 24'h000000;
            cnt_d = 2'd0;
        end else if (push) begin
            buf_d = {buf_q[15:0], data};
            cnt_d = cnt_q + 2'd1;
        end
    end

    // full_word is only meaningful in the cycle the fourth byte is pushed.
    assign full_word = {buf_q, data};
    assign pad_word  = pad_partial(buf_q, cnt_q);
    assign byte_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_loader
// Description : Boot-time byte-stream loader writing packed words to instr RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
    parameter int          DEPTH_BYTES = 4096,
    parameter int          CNT_W       = $clog2(DEPTH_BYTES/4) + 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    input  logic             byte_last,
    output logic             byte_ready,
    output logic             we,
    output logic [31:0]      waddr,
    output logic [31:0]      wdata,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [CNT_W-1:0] words_written
);

    localparam logic [CNT_W-1:0] CAP_WORDS = CNT_W'(DEPTH_BYTES / 4);
    localparam logic [CNT_W-1:0] ONE_WORD  = CNT_W'(1);
    localparam logic [31:0]      ADDR_STEP = 32'd4;

    loader_state_t    state_q, state_d;
    logic             we_q, we_d;
    logic [31:0]      waddr_q, waddr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      next_addr_q, next_addr_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;

    logic             w_accept;
    logic             w_full;
    logic             w_word_done;
    logic             w_pk_clear;
    logic [1:0]       w_byte_cnt;
    logic [31:0]      w_full_word;
    logic [31:0]      w_pad_word;

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_pk_clear),
        .push      (w_accept),
        .data      (byte_data),
        .byte_cnt  (w_byte_cnt),
        .full_word (w_full_word),
        .pad_word  (w_pad_word)
    );

    assign w_accept    = byte_valid && (state_q == LOAD);
    assign w_full      = (words_q == CAP_WORDS);
    assign w_word_done = w_accept && (w_byte_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            waddr_q     <= BASE_ADDR;
            wdata_q     <= 32'h00000000;
            next_addr_q <= BASE_ADDR;
            words_q     <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            next_addr_q <= next_addr_d;
            words_q     <= words_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        next_addr_d = next_addr_q;
        words_d     = words_q;
        overflow_d  = overflow_q;
        w_pk_clear  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = LOAD;
                    next_addr_d = BASE_ADDR;
                    words_d     = '0;
                    overflow_d  = 1'b0;
                    w_pk_clear  = 1'b1;
                end
            end
            LOAD: begin
                if (w_accept) begin
                    if (w_full) begin
                        overflow_d = 1'b1;
                    end else if (w_word_done) begin
                        we_d        = 1'b1;
                        wdata_d     = w_full_word;
                        waddr_d     = next_addr_q;
                        next_addr_d = next_addr_q + ADDR_STEP;
                        words_d     = words_q + ONE_WORD;
                    end
                    // A trailing partial word only needs FLUSH if it can still be stored.
                    if (byte_last) begin
                        state_d = (w_word_done || w_full) ? DONE : FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (!w_full) begin
                    we_d        = 1'b1;
                    wdata_d     = w_pad_word;
                    waddr_d     = next_addr_q;
                    next_addr_d = next_addr_q + ADDR_STEP;
                    words_d     = words_q + ONE_WORD;
                end
                w_pk_clear = 1'b1;
                state_d    = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // done trails entry into DONE by one cycle so it follows the final write strobe.
    always_comb begin
        done_d = (state_q == DONE) && (state_d == DONE);
    end

    always_comb begin
        byte_ready    = (state_q == LOAD);
        busy          = (state_q != IDLE) && !done_q;
        done          = done_q;
        we            = we_q;
        waddr         = waddr_q;
        wdata         = wdata_q;
        overflow      = overflow_q;
        words_written = words_q;
    end

endmodule
`default_nettype wire
